// File: rtl/rtc_pkg.sv
// Shared types for the RTC write arbiter: FSM encoding, requester IDs, default register width.
package rtc_pkg;
  localparam int NUM_REQ        = 3;
  localparam int DEFAULT_DATA_W = 60;

  localparam logic [1:0] REQ_MCU  = 2'd0;
  localparam logic [1:0] REQ_SRTC = 2'd1;
  localparam logic [1:0] REQ_AUX  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT,
    ST_DONE
  } state_t;

  // Round-robin successor; aux wraps back to mcu.
  function automatic logic [1:0] req_next(input logic [1:0] id);
    return (id == REQ_AUX) ? REQ_MCU : id + 2'd1;
  endfunction
endpackage

// File: rtl/rtc_req_slot.sv
// One requester slot: 2-flop sync + edge detect, pending flag, last-wins data buffer.
// Rising edge sets pending 3 edges after the input rises; a new edge beats a same-cycle clear.
module rtc_req_slot import rtc_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clr_i,
  output logic              pending_o,
  output logic [DATA_W-1:0] data_o
);
  logic [2:0]        sync_q, sync_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    sync_d    = {sync_q[1:0], we_i};
    pending_d = pending_q;
    data_d    = data_q;
    if (rise) begin
      pending_d = 1'b1;
      data_d    = data_i;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      pending_q <= 1'b0;
      data_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      pending_q <= pending_d;
      data_q    <= data_d;
    end
  end

  assign pending_o = pending_q;
  assign data_o    = data_q;
endmodule

// File: rtl/rtc_write_arbiter.sv
// Round-robin arbiter committing MCU/S-RTC/aux writes to the RTC core clear of its carry update.
// Optional RTC_WRITE_LOG_EN adds last_src/write_count commit logging outputs.
module rtc_write_arbiter import rtc_pkg::*; #(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int WE_CYCLES = 4
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic              mcu_we,
  input  logic [DATA_W-1:0] mcu_data,
  input  logic              srtc_we,
  input  logic [DATA_W-1:0] srtc_data,
  input  logic              aux_we,
  input  logic [DATA_W-1:0] aux_data,
  input  logic              rtc_busy,
  input  logic [DATA_W-1:0] rtc_cur,
  output logic              rtc_we_out,
  output logic [DATA_W-1:0] rtc_data_out,
  output logic [DATA_W-1:0] rtc_snap,
  output logic [2:0]        pending,
  output logic [2:0]        done
`ifdef RTC_WRITE_LOG_EN
  ,output logic [1:0]       last_src
  ,output logic [15:0]      write_count
`endif
);
  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [2:0]        done_q, done_d;

  logic [NUM_REQ-1:0] we_vec, pend, clr;
  logic [DATA_W-1:0]  din      [NUM_REQ];
  logic [DATA_W-1:0]  slot_dat [NUM_REQ];
  logic               pick_vld;
  logic [1:0]         pick_id, cand;

  assign we_vec = {aux_we, srtc_we, mcu_we};
  assign din[0] = mcu_data;
  assign din[1] = srtc_data;
  assign din[2] = aux_data;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    rtc_req_slot #(.DATA_W(DATA_W)) u_slot (
      .clk_i     (clkin),
      .rst_i     (reset),
      .we_i      (we_vec[i]),
      .data_i    (din[i]),
      .clr_i     (clr[i]),
      .pending_o (pend[i]),
      .data_o    (slot_dat[i])
    );
  end

  // First pending requester scanning cyclically from the pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = ptr_q;
    cand     = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && pend[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
      cand = req_next(cand);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    snap_d  = snap_q;
    done_d  = '0;
    clr     = '0;
    // Snapshot freezes while the core carries or while our own write is landing.
    if (!rtc_busy && state_q != ST_COMMIT && state_q != ST_DONE) snap_d = rtc_cur;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_id;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!rtc_busy) begin
          wdat_d         = slot_dat[grant_q];
          clr[grant_q]   = 1'b1;
          cnt_d          = 3'(WE_CYCLES - 1);
          we_d           = 1'b1;
          state_d        = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (cnt_q == 3'd0) begin
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        done_d[grant_q] = 1'b1;
        ptr_d           = req_next(grant_q);
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= REQ_MCU;
      ptr_q   <= REQ_MCU;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      snap_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
    end
  end

  assign rtc_we_out   = we_q;
  assign rtc_data_out = wdat_q;
  assign rtc_snap     = snap_q;
  assign pending      = pend;
  assign done         = done_q;

`ifdef RTC_WRITE_LOG_EN
  logic [1:0]  last_src_q;
  logic [15:0] wcnt_q;

  always_ff @(posedge clkin) begin
    if (reset) begin
      last_src_q <= 2'd3;
      wcnt_q     <= '0;
    end else if (state_q == ST_DONE) begin
      last_src_q <= grant_q;
      wcnt_q     <= wcnt_q + 16'd1;
    end
  end

  assign last_src    = last_src_q;
  assign write_count = wcnt_q;
`endif
endmodule

// File: tb/tb_rtc_write_arbiter.sv
// Scoreboard bench for rtc_write_arbiter: directed latency/busy/reset/snapshot cases plus random batches.
module tb_rtc_write_arbiter;
  localparam int DW  = 60;
  localparam int WEC = 4;

  logic          clkin = 1'b0;
  logic          reset;
  logic          mcu_we, srtc_we, aux_we, rtc_busy;
  logic [DW-1:0] mcu_data, srtc_data, aux_data, rtc_cur;
  logic          rtc_we_out;
  logic [DW-1:0] rtc_data_out, rtc_snap;
  logic [2:0]    pending, done;

  always #5 clkin = ~clkin;

  rtc_write_arbiter #(.DATA_W(DW), .WE_CYCLES(WEC)) dut (
    .clkin(clkin), .reset(reset),
    .mcu_we(mcu_we), .mcu_data(mcu_data),
    .srtc_we(srtc_we), .srtc_data(srtc_data),
    .aux_we(aux_we), .aux_data(aux_data),
    .rtc_busy(rtc_busy), .rtc_cur(rtc_cur),
    .rtc_we_out(rtc_we_out), .rtc_data_out(rtc_data_out),
    .rtc_snap(rtc_snap), .pending(pending), .done(done)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] mdl_data [3];
  int            model_ptr = 0;
  int            errors = 0;
  int            checks = 0;
  bit            busy_rand = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Drive point: 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
      if (busy_rand) begin
        rtc_busy = ($urandom_range(0, 3) == 0);
        rtc_cur  = rand_data();
      end
    end
  endtask

  task automatic drive_we(input int id, input logic v);
    case (id)
      0:       mcu_we  = v;
      1:       srtc_we = v;
      default: aux_we  = v;
    endcase
  endtask

  task automatic drive_data(input int id, input logic [DW-1:0] d);
    mdl_data[id] = d;
    case (id)
      0:       mcu_data  = d;
      1:       srtc_data = d;
      default: aux_data  = d;
    endcase
  endtask

  // Requests raised together are served in cyclic order from the model pointer.
  task automatic push_order(input logic [2:0] mask);
    int id;
    int last;
    last = model_ptr;
    for (int k = 0; k < 3; k++) begin
      id = (model_ptr + k) % 3;
      if (mask[id]) begin
        sb_q.push_back('{id, mdl_data[id]});
        last = id;
      end
    end
    model_ptr = (last + 1) % 3;
  endtask

  task automatic wait_drain(input int budget);
    int b;
    b = budget;
    while ((sb_q.size() != 0 || pending != 3'b000 || rtc_we_out) && b > 0) begin
      tick(1);
      b--;
    end
    if (b == 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d commits still expected, pending=%b", sb_q.size(), pending);
      sb_q.delete();
    end
    tick(3);
  endtask

  // Monitor: pops the scoreboard on every strobe start, checks width and the done pulse.
  initial begin : monitor
    bit   prev_we;
    bit   chk_done;
    int   cur_id;
    int   width;
    exp_t e;
    prev_we  = 0;
    chk_done = 0;
    cur_id   = 0;
    width    = 0;
    forever begin
      @(negedge clkin);
      if (reset) begin
        prev_we  = 0;
        chk_done = 0;
        width    = 0;
      end else begin
        if (chk_done) begin
          check("done_pulse", 64'(done), 64'(1 << cur_id));
          chk_done = 0;
        end else if (done != 3'b000) begin
          check("spurious_done", 64'(done), 64'd0);
        end
        if (rtc_we_out && !prev_we) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got data %0h expected no commit", rtc_data_out);
          end else begin
            e = sb_q.pop_front();
            cur_id = e.id;
            check("commit_data", 64'(rtc_data_out), 64'(e.data));
          end
          width = 1;
        end else if (rtc_we_out) begin
          width++;
        end else if (prev_we) begin
          check("strobe_width", 64'(width), 64'(WEC));
          chk_done = 1;
        end
        prev_we = rtc_we_out;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [2:0] mask;
    int         tgt;
    bit         seen;
    reset = 1'b1;
    mcu_we = 0; srtc_we = 0; aux_we = 0; rtc_busy = 0;
    mcu_data = '0; srtc_data = '0; aux_data = '0;
    rtc_cur = 60'hABC;
    tick(3);
    check("rst_we_out", 64'(rtc_we_out), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data_out", 64'(rtc_data_out), 64'd0);
    check("rst_snap", 64'(rtc_snap), 64'd0);
    reset = 1'b0;
    tick(2);

    // Uncontended MCU write: strobe on the 5th edge, snapshot frozen across COMMIT/DONE.
    drive_data(0, 60'h0123456789ABCDE);
    push_order(3'b001);
    mcu_we = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      check("t1_no_early_strobe", 64'(rtc_we_out), 64'd0);
      if (e == 2) mcu_we = 1'b0;
      if (e == 3) check("t1_pending", 64'(pending), 64'b001);
    end
    tick(1);
    check("t1_strobe_edge5", 64'(rtc_we_out), 64'd1);
    check("t1_data_out", 64'(rtc_data_out), 64'h0123456789ABCDE);
    rtc_cur = 60'h5555;
    tick(4);
    check("t1_strobe_off", 64'(rtc_we_out), 64'd0);
    check("t1_snap_hold_commit", 64'(rtc_snap), 64'hABC);
    tick(1);
    check("t1_done", 64'(done), 64'b001);
    check("t1_snap_hold_done", 64'(rtc_snap), 64'hABC);
    tick(1);
    check("t1_snap_update", 64'(rtc_snap), 64'h5555);
    check("t1_done_one_cycle", 64'(done), 64'd0);
    check("t1_pending_clear", 64'(pending), 64'd0);
    tick(2);

    // S-RTC request held off by a long carry update.
    rtc_busy = 1'b1;
    drive_data(1, rand_data());
    push_order(3'b010);
    srtc_we = 1'b1;
    tick(2);
    srtc_we = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("t2_no_strobe_busy", 64'(rtc_we_out), 64'd0);
    end
    rtc_busy = 1'b0;
    tick(1);
    check("t2_strobe_after_busy", 64'(rtc_we_out), 64'd1);
    wait_drain(100);

    // Reset in the 2nd COMMIT cycle of aux, with mcu still pending behind it.
    drive_data(2, rand_data());
    drive_data(0, rand_data());
    push_order(3'b101);
    aux_we = 1'b1;
    mcu_we = 1'b1;
    tick(2);
    aux_we = 1'b0;
    mcu_we = 1'b0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      tick(1);
      seen = rtc_we_out;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL t3_strobe_timeout: got no strobe expected one within 30 cycles");
    end
    tick(1);
    reset = 1'b1;
    tick(1);
    check("t3_we_dropped", 64'(rtc_we_out), 64'd0);
    check("t3_pending_cleared", 64'(pending), 64'd0);
    check("t3_data_out_cleared", 64'(rtc_data_out), 64'd0);
    reset = 1'b0;
    sb_q.delete();
    model_ptr = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      check("t3_no_done", 64'(done), 64'd0);
      check("t3_no_commit", 64'(rtc_we_out), 64'd0);
    end

    // All three at once; aux re-requests with new data before its grant.
    drive_data(0, rand_data());
    drive_data(1, rand_data());
    drive_data(2, 60'hA0A0A0A0A0A0A0A);
    push_order(3'b111);
    mcu_we = 1'b1; srtc_we = 1'b1; aux_we = 1'b1;
    tick(2);
    mcu_we = 1'b0; srtc_we = 1'b0; aux_we = 1'b0;
    tick(2);
    drive_data(2, 60'hB0B0B0B0B0B0B0B);
    for (int i = 0; i < sb_q.size(); i++)
      if (sb_q[i].id == 2) sb_q[i].data = mdl_data[2];
    aux_we = 1'b1;
    tick(2);
    aux_we = 1'b0;
    wait_drain(200);
    check("t4_pending_zero", 64'(pending), 64'd0);

    // Snapshot holds through busy, updates on the first non-busy idle cycle.
    rtc_cur = 60'h111;
    tick(2);
    check("t5_snap_track", 64'(rtc_snap), 64'h111);
    rtc_busy = 1'b1;
    rtc_cur  = 60'h222;
    tick(3);
    check("t5_snap_hold_busy", 64'(rtc_snap), 64'h111);
    rtc_busy = 1'b0;
    tick(1);
    check("t5_snap_after_busy", 64'(rtc_snap), 64'h222);

    // Random batches with random busy and occasional last-wins re-requests.
    busy_rand = 1;
    for (int b = 0; b < 30; b++) begin
      mask = 3'($urandom_range(1, 7));
      for (int id = 0; id < 3; id++)
        if (mask[id]) drive_data(id, rand_data());
      push_order(mask);
      for (int id = 0; id < 3; id++)
        if (mask[id]) drive_we(id, 1'b1);
      tick(2);
      for (int id = 0; id < 3; id++) drive_we(id, 1'b0);
      tick(2);
      if (sb_q.size() >= 2 && $urandom_range(0, 1) == 1) begin
        tgt = sb_q[$].id;
        drive_data(tgt, rand_data());
        sb_q[sb_q.size() - 1].data = mdl_data[tgt];
        drive_we(tgt, 1'b1);
        tick(2);
        drive_we(tgt, 1'b0);
      end
      wait_drain(400);
    end
    busy_rand = 0;
    rtc_busy  = 1'b0;
    tick(2);
    check("final_pending_zero", 64'(pending), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
